// File: rtl/switch_code_sequencer.sv
// ---------------------------------------------------------------------------
// switch_code_sequencer
//
// Upstream stage of the 4-to-16 LED decoder. It produces the 4-bit code that
// drives the decoder select input.
//   - The 4 slide switches, the direction switch and the 2 push buttons are
//     synchronised through two flops each and then debounced.
//   - MANUAL mode: the debounced switch value is the code.
//   - AUTO mode: a prescaled up/down counter walks the code through 0..15
//     with wraparound, so the lit LED chases around the ring.
//
// Parameters
//   DEB_CYCLES  consecutive stable samples needed to accept a new level (>=2)
//   STEP_DIV    clk cycles per automatic step (>=2)
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   InSwitch   in   4  raw slide switches (asynchronous, bouncy)
//   btn_mode   in   1  raw push button: toggles MANUAL / AUTO
//   btn_step   in   1  raw push button: pause / single-step in AUTO
//   dir        in   1  raw switch: 0 = count up, 1 = count down
//   code_out   out  4  registered code to the decoder select input
//   mode_auto  out  1  high while in AUTO_RUN or AUTO_HOLD
//   step_tick  out  1  one-cycle pulse whenever an auto/single step changes
//                      code_out
// ---------------------------------------------------------------------------
module switch_code_sequencer #(
    parameter int DEB_CYCLES = 20,
    parameter int STEP_DIV   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] InSwitch,
    input  logic       btn_mode,
    input  logic       btn_step,
    input  logic       dir,
    output logic [3:0] code_out,
    output logic       mode_auto,
    output logic       step_tick
);

    // Input bit map inside the shared synchroniser / debouncer vectors.
    localparam int NIN      = 7;
    localparam int IDX_DIR  = 4;
    localparam int IDX_MODE = 5;
    localparam int IDX_STEP = 6;

    localparam int CW = $clog2(DEB_CYCLES);
    localparam int PW = $clog2(STEP_DIV);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_MANUAL    = 2'd0,
        ST_AUTO_RUN  = 2'd1,
        ST_AUTO_HOLD = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronise and debounce every raw input.
    // -----------------------------------------------------------------------
    logic [NIN-1:0] w_raw;
    logic [NIN-1:0] r_s1;
    logic [NIN-1:0] r_s2;
    logic [NIN-1:0] r_deb;
    logic [CW-1:0]  r_cnt [NIN];

    assign w_raw = {btn_step, btn_mode, dir, InSwitch};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_deb <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so
            // clearing it in reset costs nothing and keeps startup defined.
            for (int i = 0; i < NIN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let s1 -> s2 -> deb form a true
            // shift chain; blocking ones would collapse it in one edge.
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < NIN; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_LAST) begin
                    // DEB_CYCLES consecutive differing samples: accept.
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Button rising-edge pulses. Held buttons give a single pulse.
    // -----------------------------------------------------------------------
    logic r_mode_q;
    logic r_step_q;
    logic w_mode_p;
    logic w_step_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q <= 1'b0;
            r_step_q <= 1'b0;
        end else begin
            r_mode_q <= r_deb[IDX_MODE];
            r_step_q <= r_deb[IDX_STEP];
        end
    end

    assign w_mode_p = r_deb[IDX_MODE] & ~r_mode_q;
    assign w_step_p = r_deb[IDX_STEP] & ~r_step_q;

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // -----------------------------------------------------------------------
    state_t        r_state;
    logic [3:0]    r_code;
    logic          r_mode_auto;
    logic          r_step_tick;
    logic [PW-1:0] r_presc;
    logic [3:0]    w_sw;
    logic [3:0]    w_code_next;

    assign w_sw = r_deb[3:0];

    // 4-bit arithmetic wraps naturally: F+1 = 0 and 0-1 = F.
    assign w_code_next = r_deb[IDX_DIR] ? (r_code - 4'd1) : (r_code + 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_MANUAL;
            r_code      <= 4'd0;
            r_mode_auto <= 1'b0;
            r_step_tick <= 1'b0;
            r_presc     <= '0;
        end else begin
            // The tick is a pulse: low unless a step below raises it.
            r_step_tick <= 1'b0;
            case (r_state)
                ST_MANUAL: begin
                    if (w_mode_p) begin
                        // Enter AUTO from the code currently shown.
                        r_state     <= ST_AUTO_RUN;
                        r_mode_auto <= 1'b1;
                        r_presc     <= '0;
                    end else begin
                        r_code <= w_sw;
                    end
                end

                ST_AUTO_RUN: begin
                    // mode_p has priority over step_p and over a terminal
                    // count landing in the same cycle.
                    if (w_mode_p) begin
                        r_state     <= ST_MANUAL;
                        r_mode_auto <= 1'b0;
                        r_presc     <= '0;
                    end else if (w_step_p) begin
                        r_state <= ST_AUTO_HOLD;
                        r_presc <= '0;
                    end else if (r_presc == PRE_LAST) begin
                        r_presc     <= '0;
                        r_code      <= w_code_next;
                        r_step_tick <= 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end

                ST_AUTO_HOLD: begin
                    r_presc <= '0;
                    if (w_mode_p) begin
                        r_state     <= ST_MANUAL;
                        r_mode_auto <= 1'b0;
                    end else if (w_step_p) begin
                        r_code      <= w_code_next;
                        r_step_tick <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_MANUAL;
                    r_mode_auto <= 1'b0;
                    r_presc     <= '0;
                end
            endcase
        end
    end

    assign code_out  = r_code;
    assign mode_auto = r_mode_auto;
    assign step_tick = r_step_tick;

endmodule

// File: tb/tb_switch_code_sequencer.sv
// ---------------------------------------------------------------------------
// tb_switch_code_sequencer
//
// Directed bench for switch_code_sequencer with DEB_CYCLES=4, STEP_DIV=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "edge k" below means the k-th rising edge after a stimulus
// change. Scenarios run back to back and share DUT state.
// ---------------------------------------------------------------------------
module tb_switch_code_sequencer;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] InSwitch;
    logic       btn_mode;
    logic       btn_step;
    logic       dir;
    logic [3:0] code_out;
    logic       mode_auto;
    logic       step_tick;

    int errors = 0;
    int checks = 0;

    switch_code_sequencer #(
        .DEB_CYCLES (DEB),
        .STEP_DIV   (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .InSwitch  (InSwitch),
        .btn_mode  (btn_mode),
        .btn_step  (btn_step),
        .dir       (dir),
        .code_out  (code_out),
        .mode_auto (mode_auto),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst      = 1'b1;
        InSwitch = 4'hF;
        btn_mode = 1'b0;
        btn_step = 1'b0;
        dir      = 1'b0;
        step(2);
        checks++; if (code_out !== 4'h0) begin errors++; $display("FAIL reset_code: got %h want %h", code_out, 4'h0); end
        checks++; if (mode_auto !== 1'b0) begin errors++; $display("FAIL reset_mode_auto: got %b want 0", mode_auto); end
        checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_step_tick: got %b want 0", step_tick); end
        rst = 1'b0;
        step(6);
        checks++; if (code_out !== 4'h0) begin errors++; $display("FAIL reset_latency_edge6: got %h want %h", code_out, 4'h0); end
        step(1);
        checks++; if (code_out !== 4'hF) begin errors++; $display("FAIL reset_latency_edge7: got %h want %h", code_out, 4'hF); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_debounce();
        InSwitch = 4'h0;
        step(10);
        checks++; if (code_out !== 4'h0) begin errors++; $display("FAIL deb_settle0: got %h want %h", code_out, 4'h0); end
        InSwitch = 4'hA;
        step(6);
        checks++; if (code_out !== 4'h0) begin errors++; $display("FAIL deb_edge6: got %h want %h", code_out, 4'h0); end
        step(1);
        checks++; if (code_out !== 4'hA) begin errors++; $display("FAIL deb_edge7: got %h want %h", code_out, 4'hA); end
        // 3-cycle glitch, one cycle shorter than the debounce window.
        InSwitch = 4'h5;
        step(3);
        InSwitch = 4'hA;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            checks++; if (code_out !== 4'hA) begin errors++; $display("FAIL deb_glitch k=%0d: got %h want %h", k, code_out, 4'hA); end
        end
    endtask

    // -----------------------------------------------------------------------
    // mode_p acts at edge 7 after the press; steps at edges 15, 23, 31.
    task automatic test_auto_up_wrap();
        logic [3:0] exp_code;
        logic       exp_tick;
        InSwitch = 4'hE;
        step(10);
        checks++; if (code_out !== 4'hE) begin errors++; $display("FAIL up_start: got %h want %h", code_out, 4'hE); end
        btn_mode = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step(1);
            if (k == 8) btn_mode = 1'b0;
            if (k < 15)      exp_code = 4'hE;
            else if (k < 23) exp_code = 4'hF;
            else if (k < 31) exp_code = 4'h0;
            else             exp_code = 4'h1;
            exp_tick = (k == 15) || (k == 23) || (k == 31);
            checks++; if (code_out !== exp_code) begin errors++; $display("FAIL up_code k=%0d: got %h want %h", k, code_out, exp_code); end
            checks++; if (step_tick !== exp_tick) begin errors++; $display("FAIL up_tick k=%0d: got %b want %b", k, step_tick, exp_tick); end
            if (k == 6) begin
                checks++; if (mode_auto !== 1'b0) begin errors++; $display("FAIL up_mode_auto_pre: got %b want 0", mode_auto); end
            end
            if (k == 7) begin
                checks++; if (mode_auto !== 1'b1) begin errors++; $display("FAIL up_mode_auto_post: got %b want 1", mode_auto); end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Starts right after the step to 1 (prescaler at 0, AUTO_RUN).
    task automatic test_hold_step_down();
        logic [3:0] exp_code;
        logic       exp_tick;
        logic [3:0] prev;
        logic [3:0] next;
        dir = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            step(1);
            if (j < 8)       exp_code = 4'h1;
            else if (j < 16) exp_code = 4'h0;
            else             exp_code = 4'hF;
            exp_tick = (j == 8) || (j == 16);
            checks++; if (code_out !== exp_code) begin errors++; $display("FAIL down_code j=%0d: got %h want %h", j, code_out, exp_code); end
            checks++; if (step_tick !== exp_tick) begin errors++; $display("FAIL down_tick j=%0d: got %b want %b", j, step_tick, exp_tick); end
            if (j == 16) btn_step = 1'b1;   // HOLD entered at edge 23
            if (j == 24) btn_step = 1'b0;
        end
        for (int n = 0; n < 40; n++) begin
            step(1);
            checks++; if (code_out !== 4'hF || step_tick !== 1'b0) begin
                errors++; $display("FAIL hold_still n=%0d: got code=%h tick=%b want code=F tick=0", n, code_out, step_tick);
            end
        end
        checks++; if (mode_auto !== 1'b1) begin errors++; $display("FAIL hold_mode_auto: got %b want 1", mode_auto); end
        prev = 4'hF;
        for (int p = 0; p < 2; p++) begin
            next = (p == 0) ? 4'hE : 4'hD;
            btn_step = 1'b1;
            for (int e = 1; e <= 20; e++) begin
                step(1);
                if (e == 8) btn_step = 1'b0;
                exp_code = (e < 7) ? prev : next;
                exp_tick = (e == 7);
                checks++; if (code_out !== exp_code) begin errors++; $display("FAIL single_step p=%0d e=%0d: got %h want %h", p, e, code_out, exp_code); end
                checks++; if (step_tick !== exp_tick) begin errors++; $display("FAIL single_tick p=%0d e=%0d: got %b want %b", p, e, step_tick, exp_tick); end
            end
            prev = next;
        end
    endtask

    // -----------------------------------------------------------------------
    // Both buttons land at edge 31, which is also a prescaler terminal count.
    task automatic test_conflict();
        logic [3:0] exp_code;
        logic       exp_tick;
        logic       exp_auto;
        btn_mode = 1'b1;
        step(8);
        btn_mode = 1'b0;
        step(12);
        checks++; if (mode_auto !== 1'b0) begin errors++; $display("FAIL conf_to_manual: got %b want 0", mode_auto); end
        checks++; if (code_out !== 4'hE) begin errors++; $display("FAIL conf_manual_code: got %h want %h", code_out, 4'hE); end
        InSwitch = 4'h3;
        step(10);
        checks++; if (code_out !== 4'h3) begin errors++; $display("FAIL conf_code3: got %h want %h", code_out, 4'h3); end
        btn_mode = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            step(1);
            if (j < 15)       exp_code = 4'h3;
            else if (j < 23)  exp_code = 4'h2;
            else if (j < 32)  exp_code = 4'h1;
            else              exp_code = 4'h6;
            exp_tick = (j == 15) || (j == 23);
            exp_auto = (j >= 7) && (j < 31);
            checks++; if (code_out !== exp_code) begin errors++; $display("FAIL conf_code j=%0d: got %h want %h", j, code_out, exp_code); end
            checks++; if (step_tick !== exp_tick) begin errors++; $display("FAIL conf_tick j=%0d: got %b want %b", j, step_tick, exp_tick); end
            checks++; if (mode_auto !== exp_auto) begin errors++; $display("FAIL conf_auto j=%0d: got %b want %b", j, mode_auto, exp_auto); end
            if (j == 8) begin
                btn_mode = 1'b0;
                InSwitch = 4'h6;
            end
            if (j == 24) begin
                btn_mode = 1'b1;
                btn_step = 1'b1;
            end
            if (j == 32) begin
                btn_mode = 1'b0;
                btn_step = 1'b0;
            end
        end
        for (int n = 0; n < 15; n++) begin
            step(1);
            checks++; if (step_tick !== 1'b0 || code_out !== 4'h6) begin
                errors++; $display("FAIL conf_after n=%0d: got code=%h tick=%b want code=6 tick=0", n, code_out, step_tick);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_mid_run_reset();
        dir      = 1'b0;
        InSwitch = 4'h9;
        step(12);
        checks++; if (code_out !== 4'h9) begin errors++; $display("FAIL mrr_code9: got %h want %h", code_out, 4'h9); end
        btn_mode = 1'b1;
        step(8);
        btn_mode = 1'b0;
        step(2);
        checks++; if (mode_auto !== 1'b1 || code_out !== 4'h9) begin
            errors++; $display("FAIL mrr_in_auto: got auto=%b code=%h want auto=1 code=9", mode_auto, code_out);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (code_out !== 4'h0) begin errors++; $display("FAIL mrr_code: got %h want %h", code_out, 4'h0); end
        checks++; if (mode_auto !== 1'b0) begin errors++; $display("FAIL mrr_mode_auto: got %b want 0", mode_auto); end
        checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL mrr_tick: got %b want 0", step_tick); end
        for (int n = 1; n <= 30; n++) begin
            step(1);
            checks++; if (step_tick !== 1'b0 || mode_auto !== 1'b0) begin
                errors++; $display("FAIL mrr_after n=%0d: got tick=%b auto=%b want 0 0", n, step_tick, mode_auto);
            end
        end
        checks++; if (code_out !== 4'h9) begin errors++; $display("FAIL mrr_reload: got %h want %h", code_out, 4'h9); end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_debounce();
        test_auto_up_wrap();
        test_hold_step_down();
        test_conflict();
        test_mid_run_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
